// File: rtl/rs_operand_dispatch_if.sv
// Operand-in / channel-out bundle between register-file read and the ALU channels.
// master drives operands and consumer ready; slave is the dispatcher.
interface rs_operand_dispatch_if #(
  parameter int N      = 16,
  parameter int NUM_CH = 8,
  parameter int SEL    = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL-1:0]        op_opcode;
  logic [N-1:0]          rs1_reg_val;
  logic [N-1:0]          rs2_reg_val;
  logic [NUM_CH-1:0]     ch_valid;
  logic [NUM_CH-1:0]     ch_ready;
  logic [NUM_CH*N-1:0]   ch_rs1;
  logic [NUM_CH*N-1:0]   ch_rs2;

  modport master (
    output in_valid, op_opcode, rs1_reg_val, rs2_reg_val, ch_ready,
    input  in_ready, ch_valid, ch_rs1, ch_rs2
  );

  modport slave (
    input  in_valid, op_opcode, rs1_reg_val, rs2_reg_val, ch_ready,
    output in_ready, ch_valid, ch_rs1, ch_rs2
  );
endinterface

// File: rtl/rs_operand_dispatch.sv
// Registered operand dispatcher: routes one {rs1, rs2} pair per cycle into one of
// NUM_CH single-entry channel holding registers selected by op_opcode.
module rs_operand_dispatch #(
  parameter int N      = 16,
  parameter int NUM_CH = 8,
  parameter int SEL    = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  rs_operand_dispatch_if.slave bus,
  output logic                illegal_pulse,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0]   valid_q;
  logic [NUM_CH*N-1:0] rs1_q;
  logic [NUM_CH*N-1:0] rs2_q;
  logic [NUM_CH-1:0]   sel_hot;
  logic [NUM_CH-1:0]   slot_free;
  logic [NUM_CH-1:0]   load;
  logic                legal;
  logic                ready;
  logic                accept;

  // An opcode with no matching channel decodes to all-zero, which is what marks it illegal.
  always_comb begin
    sel_hot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.op_opcode == SEL'(k)) sel_hot[k] = 1'b1;
    end
  end

  assign legal     = |sel_hot;
  assign slot_free = ~valid_q | bus.ch_ready;
  assign ready     = !flush && (!legal || |(sel_hot & slot_free));
  assign accept    = bus.in_valid && ready;
  assign load      = accept ? sel_hot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (flush) begin
          valid_q[k] <= 1'b0;
        end else if (load[k]) begin
          valid_q[k]         <= 1'b1;
          rs1_q[k*N +: N]    <= bus.rs1_reg_val;
          rs2_q[k*N +: N]    <= bus.rs2_reg_val;
        end else if (bus.ch_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Dropped pairs are counted only when actually accepted; flush blocks acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_pulse <= 1'b0;
      illegal_cnt   <= '0;
    end else begin
      illegal_pulse <= accept && !legal;
      if (accept && !legal && (illegal_cnt != CNT_MAX)) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.ch_valid = valid_q;
  assign bus.ch_rs1   = rs1_q;
  assign bus.ch_rs2   = rs2_q;

endmodule

// File: tb/tb_rs_operand_dispatch.sv
// Directed plus randomized bench for rs_operand_dispatch against a per-channel
// array model of the dispatch rules.
module tb_rs_operand_dispatch;
  localparam int N      = 16;
  localparam int NUM_CH = 8;
  localparam int SEL    = 4;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             illegal_pulse;
  logic [CNT_W-1:0] illegal_cnt;

  rs_operand_dispatch_if #(.N(N), .NUM_CH(NUM_CH), .SEL(SEL)) bus ();

  rs_operand_dispatch #(.N(N), .NUM_CH(NUM_CH), .SEL(SEL), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .bus           (bus),
    .illegal_pulse (illegal_pulse),
    .illegal_cnt   (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          mv [NUM_CH];
  logic [N-1:0] m1 [NUM_CH];
  logic [N-1:0] m2 [NUM_CH];
  int          mcnt;
  bit          mpulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mv[k] = 1'b0;
      m1[k] = '0;
      m2[k] = '0;
    end
    mcnt   = 0;
    mpulse = 1'b0;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("ch_valid[%0d]", k), 32'(bus.ch_valid[k]), 32'(mv[k]));
      chk($sformatf("ch_rs1[%0d]", k), 32'(bus.ch_rs1[k*N +: N]), 32'(m1[k]));
      chk($sformatf("ch_rs2[%0d]", k), 32'(bus.ch_rs2[k*N +: N]), 32'(m2[k]));
    end
    chk("illegal_pulse", 32'(illegal_pulse), 32'(mpulse));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
  endtask

  // One clock: check in_ready mid-cycle, apply the rules at the edge, compare after it.
  task automatic step();
    bit exp_rdy;
    bit acc;
    int op;
    @(negedge clk);
    op = int'(bus.op_opcode);
    if (flush)                exp_rdy = 1'b0;
    else if (op >= NUM_CH)    exp_rdy = 1'b1;
    else                      exp_rdy = !mv[op] || bus.ch_ready[op];
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    acc    = bus.in_valid && exp_rdy;
    mpulse = acc && (op >= NUM_CH);
    if (mpulse && mcnt < CMAX) mcnt++;
    for (int k = 0; k < NUM_CH; k++) begin
      if (flush) mv[k] = 1'b0;
      else if (acc && op == k) begin
        mv[k] = 1'b1;
        m1[k] = bus.rs1_reg_val;
        m2[k] = bus.rs2_reg_val;
      end else if (bus.ch_ready[k]) mv[k] = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input int op, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.in_valid    = v;
    bus.op_opcode   = SEL'(op);
    bus.rs1_reg_val = a;
    bus.rs2_reg_val = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.ch_ready = '0;
    drive(1'b0, 0, '0, '0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset ch_valid", 32'(bus.ch_valid), 32'h0);
    chk("reset illegal_cnt", 32'(illegal_cnt), 32'h0);
    chk("reset ch_rs1", 32'(bus.ch_rs1[31:0]), 32'h0);
    check_outputs();
    rst_n = 1'b1;

    // Reset then dispatch
    drive(1'b1, 2, 16'h1234, 16'h00FF);
    step();
    chk("dispatch valid", 32'(bus.ch_valid), 32'h04);
    chk("dispatch rs1", 32'(bus.ch_rs1[2*N +: N]), 32'h1234);
    chk("dispatch rs2", 32'(bus.ch_rs2[2*N +: N]), 32'h00FF);

    // Backpressure on channel 2, channel 5 still loads
    drive(1'b1, 2, 16'hAAAA, 16'hBBBB);
    step();
    chk("backpressure hold", 32'(bus.ch_rs1[2*N +: N]), 32'h1234);
    drive(1'b1, 5, 16'h5555, 16'h6666);
    step();
    chk("bypass load", 32'(bus.ch_valid), 32'h24);

    // Drain then stream four pairs through channel 0
    drive(1'b0, 0, '0, '0);
    bus.ch_ready = '1;
    step();
    bus.ch_ready = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 0, N'(i), N'(i + 16));
      step();
      chk("stream rs1", 32'(bus.ch_rs1[N-1:0]), 32'(i));
      chk("stream valid", 32'(bus.ch_valid[0]), 32'h1);
    end
    drive(1'b0, 0, '0, '0);
    step();

    // Illegal opcode
    bus.ch_ready = '0;
    drive(1'b1, 9, 16'hDEAD, 16'hBEEF);
    step();
    chk("illegal pulse", 32'(illegal_pulse), 32'h1);
    chk("illegal cnt", 32'(illegal_cnt), 32'h1);
    drive(1'b0, 0, '0, '0);
    step();
    chk("illegal pulse low", 32'(illegal_pulse), 32'h0);

    // Flush with channels 1, 3, 7 valid
    drive(1'b1, 1, 16'h0101, 16'h1010); step();
    drive(1'b1, 3, 16'h0303, 16'h3030); step();
    drive(1'b1, 7, 16'h0707, 16'h7070); step();
    flush = 1'b1;
    drive(1'b1, 4, 16'h0404, 16'h4040);
    step();
    flush = 1'b0;
    chk("flush valid", 32'(bus.ch_valid), 32'h0);
    chk("flush cnt", 32'(illegal_cnt), 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 15) == 0);
      bus.ch_ready = NUM_CH'($urandom);
      drive(1'($urandom), int'($urandom_range(0, 15)), N'($urandom), N'($urandom));
      step();
    end
    flush = 1'b0;

    // Saturation of the illegal counter
    bus.ch_ready = '1;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 8 + int'($urandom_range(0, 7)), N'($urandom), N'($urandom));
      step();
    end
    chk("cnt saturated", 32'(illegal_cnt), 32'(CMAX));

    // Asynchronous reset between edges
    bus.ch_ready = '0;
    drive(1'b1, 6, 16'h6666, 16'h0606); step();
    drive(1'b1, 1, 16'h1111, 16'h0101); step();
    drive(1'b0, 0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async valid", 32'(bus.ch_valid), 32'h0);
    chk("async cnt", 32'(illegal_cnt), 32'h0);
    chk("async rs1", 32'(bus.ch_rs1[6*N +: N]), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 3, 16'hBEEF, 16'hCAFE);
    step();
    chk("post reset valid", 32'(bus.ch_valid), 32'h08);
    chk("post reset rs1", 32'(bus.ch_rs1[3*N +: N]), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_operand_dispatch.md
Name: rs_operand_dispatch

Overview:
- Registered, handshaked successor to the combinational rs1 opcode demux.
- Routes one {rs1, rs2} operand pair per cycle to one of NUM_CH functional-unit channels, selected by op_opcode.
- Each channel has its own one-entry holding register. Stalled channels therefore do not block dispatch to other channels.
- Sits between register-file read and the ALU units (add, sub, mul, div, and, or, xor, li, ...).

Parameters:
- N, 16, operand data width.
- NUM_CH, 8, number of output channels (1..2**SEL).
- SEL, 4, op_opcode width.
- CNT_W, 8, illegal-opcode counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset: asynchronous assert, active-low.
- flush  input  1  synchronous clear of all pending channel entries.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  dispatcher accepts the pair this cycle.
- op_opcode  input  SEL  channel select.
- rs1_reg_val  input  N  rs1 operand.
- rs2_reg_val  input  N  rs2 operand.
- ch_valid  output  NUM_CH  per-channel entry valid.
- ch_ready  input  NUM_CH  per-channel consumer ready.
- ch_rs1  output  NUM_CH*N  flattened rs1 per channel; channel k occupies bits [k*N +: N].
- ch_rs2  output  NUM_CH*N  flattened rs2 per channel; same packing.
- illegal_pulse  output  1  one-cycle pulse when an illegal opcode is accepted.
- illegal_cnt  output  CNT_W  saturating count of illegal opcodes accepted.

Behaviour:
- Reset (rst_n low, asynchronous): clears ch_valid, ch_rs1, ch_rs2, illegal_pulse and illegal_cnt to 0. Operation resumes on the first rising edge with rst_n high. Reset mid-transfer discards all pending entries.
- Legal opcode (op_opcode < NUM_CH), s = op_opcode:
  - in_ready = !ch_valid[s] || ch_ready[s], combinational from current state.
  - Accept = in_valid && in_ready && !flush.
  - On accept, ch_rs1[s] and ch_rs2[s] load the inputs and ch_valid[s] is set at the next edge. Latency is 1 cycle from input to channel output.
- Illegal opcode (op_opcode >= NUM_CH):
  - in_ready = 1.
  - On accept the pair is dropped and illegal_pulse = 1 for the next cycle.
  - illegal_cnt increments and saturates at 2**CNT_W-1; it never wraps.
- Channel drain: when ch_valid[k] && ch_ready[k], ch_valid[k] clears at the next edge unless channel k is reloaded in the same cycle.
- Simultaneous drain and load on the same channel: the new pair loads and ch_valid stays 1. Full throughput is 1 pair/cycle per channel with no bubble.
- Drain on channel j and load on channel k (j != k) in the same cycle are independent.
- Data registers hold their last value after drain (not zeroed). Consumers qualify data with ch_valid.
- ch_rs1, ch_rs2 and ch_valid are stable while ch_valid=1 && ch_ready=0.
- flush=1:
  - All ch_valid clear at the next edge.
  - in_ready is forced to 0 that cycle, so no accept occurs.
  - illegal_cnt is unaffected.
  - flush has priority over drain and load.
- Only the selected channel is written. Non-selected channels never change except through their own drain.
- in_valid=0: no state change except drains and flush.
- No combinational path from in_valid to in_ready. A path from ch_ready to in_ready is allowed.
- Every output is driven in every state; the block infers no latches.

Test Plan:
- Reset then dispatch: rst_n low 3 cycles → ch_valid=0, illegal_cnt=0. Then op_opcode=2, rs1=0x1234, rs2=0x00FF, in_valid=1, all ch_ready=0 → next cycle ch_valid=8'b0000_0100, ch_rs1[2]=0x1234, ch_rs2[2]=0x00FF, other channels unchanged.
- Backpressure: channel 2 full, ch_ready[2]=0, op_opcode=2, in_valid=1 → in_ready=0, channel 2 data held. Same cycle op_opcode=5 → in_ready=1, channel 5 loads.
- Back-to-back streaming: ch_ready[0]=1, 4 consecutive pairs 0x0001..0x0004 to opcode 0 → in_ready=1 every cycle, ch_rs1[0] shows 1,2,3,4 on successive cycles, ch_valid[0] stays 1 with no bubble.
- Illegal opcode (NUM_CH=8): op_opcode=9, in_valid=1 → in_ready=1, no ch_valid change, illegal_pulse high 1 cycle, illegal_cnt=1. With CNT_W=2 and 5 illegal opcodes → illegal_cnt saturates at 3.
- Flush: channels 1, 3, 7 valid; flush=1 with in_valid=1, op_opcode=4 → in_ready=0, next cycle ch_valid=0, channel 4 not loaded, illegal_cnt unchanged.
- Async reset mid-operation: channels valid, rst_n dropped between edges → ch_valid=0 immediately, before the next clk edge. Release rst_n → first accepted pair appears 1 cycle later.
